dmem_host_port: RTL and testbench
=================================

# dmem_host_port

Host-side access port for the data memory. On a start pulse it writes two switch operands into the operand words, clears a completion flag word, polls that flag until the ARM program sets it, then reads back the result words one at a time and hands them to the display/readout logic over a valid/ready handshake. It is the external reader/writer at the opposite end of the data memory from the processor, replacing hard-wired operand loading with a sequenced load-and-collect transaction.

## Interface

Parameters:
- `OP_A_ADDR`, default 32'h00: byte address of operand A (word 0).
- `OP_B_ADDR`, default 32'h04: byte address of operand B (word 1).
- `RES_BASE_ADDR`, default 32'h08: byte address of the first result word (word 2).
- `NUM_RES`, default 5: number of consecutive result words (suma, resta, mult, div, pow).
- `FLAG_ADDR`, default 32'h1C: byte address of the completion flag word (word 7).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum POLL cycles before error.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE, DONE or ERR.
- `op_a` in 32, `op_b` in 32: operand values (switches).
- `mem_we` out 1: memory write enable.
- `mem_a` out 32: memory byte address.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data, combinational from `mem_a`.
- `res_valid` out 1: result word available.
- `res_data` out 32: result word.
- `res_idx` out 3: index of result word (0..NUM_RES-1).
- `res_ready` in 1: consumer accepts result.
- `busy` out 1: transaction in progress.
- `done` out 1: all results delivered; held until next start.
- `timeout` out 1: flag never set; held until next start.

## Operation

- States: IDLE, WR_A, WR_B, CLR_FLAG, POLL, READ, SEND, DONE, ERR. Outputs are Moore-decoded from the state register plus datapath registers.
- IDLE/DONE/ERR: `start`=1 captures `op_a`/`op_b` into internal registers, clears `idx` and the timeout counter, → WR_A. DONE/ERR also clear `done`/`timeout` on that edge.
- WR_A: `mem_we`=1, `mem_a`=OP_A_ADDR, `mem_wd`=captured A → WR_B.
- WR_B: same with OP_B_ADDR and captured B → CLR_FLAG.
- CLR_FLAG: `mem_we`=1, `mem_a`=FLAG_ADDR, `mem_wd`=0 → POLL.
- POLL: `mem_a`=FLAG_ADDR, `mem_we`=0. If `mem_rd`≠0 → READ. Otherwise increment the counter; when it reaches TIMEOUT_CYCLES-1 → ERR. Flag takes priority if both conditions occur on the same edge.
- READ: `mem_a`=RES_BASE_ADDR + 4·idx; `res_data` ← `mem_rd` at the edge → SEND.
- SEND: `res_valid`=1, `res_idx`=idx, `res_data` stable. On `res_ready`=1: if idx=NUM_RES-1 → DONE, else idx+1 → READ. If `res_ready`=0, remain in SEND.
- `busy`=1 in every state except IDLE, DONE and ERR. `start` is ignored while busy.
- `mem_we`=1 only in WR_A, WR_B and CLR_FLAG. `mem_a`=0 and `mem_wd`=0 in all other states except POLL/READ addressing.
- Captured operands are not affected by switch changes after start.

## Timing

- Reset (asynchronous, immediate): state=IDLE, all outputs 0 (`mem_we`, `mem_a`, `mem_wd`, `res_valid`, `res_data`, `res_idx`, `busy`, `done`, `timeout`), counters 0. Reset asserted mid-transaction aborts it with no further memory writes.
- Start edge at cycle 0: WR_A during cycle 1, WR_B during 2, CLR_FLAG during 3, POLL from 4.
- Flag latency: flag seen nonzero at edge N → READ in N+1, `res_valid` high from N+2.
- Result throughput: at most one word per 2 cycles (READ + SEND). `res_valid` drops for the READ cycle between words.
- ERR is entered exactly TIMEOUT_CYCLES POLL cycles after POLL entry if the flag stays 0.
- `done`/`timeout` assert in the first cycle of DONE/ERR.

## Test plan

- Nominal: op_a=10, op_b=5, start. Memory model sees writes (0x00,10), (0x04,5), (0x1C,0) on cycles 1-3. Model CPU writes results 15, 5, 50, 2, 100000 and flag=1 at cycle 20. Expect 5 handshakes with idx 0..4 carrying those values, then `done`=1 and `busy`=0.
- Backpressure: `res_ready`=0 for 7 cycles at idx 2. Expect `res_valid` held, `res_data`=50 stable, idx does not advance. Release → idx 3 follows after one READ cycle.
- Timeout: TIMEOUT_CYCLES=16, flag never set. Expect `timeout`=1 exactly 16 cycles after POLL entry, `res_valid` never asserted, `busy`=0.
- Start handling: `start` pulses during POLL are ignored (no extra writes). A start in DONE clears `done` and repeats the write sequence. A start in ERR clears `timeout`.
- Operand capture: change op_a from 10 to 99 on cycle 1 after start. Expect the memory write at 0x00 to be 10.
- Reset mid-SEND: drop `reset_n` while `res_valid`=1. Expect all outputs 0 immediately, without waiting for a clock edge. After release, stays IDLE until start.

Source files
------------

// File: rtl/dmem_host_port_if.sv
// Host-port bundle: start/operand inputs, data-memory bus and result handshake.
// The master modport is the host port itself; the slave side is memory plus consumer.
interface dmem_host_port_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        res_valid;
  logic [31:0] res_data;
  logic [2:0]  res_idx;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    input  start, op_a, op_b, mem_rd, res_ready,
    output mem_we, mem_a, mem_wd, res_valid, res_data, res_idx, busy, done, timeout
  );

  modport slave (
    output start, op_a, op_b, mem_rd, res_ready,
    input  mem_we, mem_a, mem_wd, res_valid, res_data, res_idx, busy, done, timeout
  );
endinterface

// File: rtl/dmem_host_port.sv
// Host-side data-memory sequencer: loads two operands, clears and polls a completion
// flag, then streams the result words out over a valid/ready handshake.
module dmem_host_port #(
  parameter logic [31:0] OP_A_ADDR      = 32'h00,
  parameter logic [31:0] OP_B_ADDR      = 32'h04,
  parameter logic [31:0] RES_BASE_ADDR  = 32'h08,
  parameter int unsigned NUM_RES        = 5,
  parameter logic [31:0] FLAG_ADDR      = 32'h1C,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_host_port_if.master bus
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_RES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_CLR_FLAG, S_POLL, S_READ, S_SEND, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   op_a_q, op_b_q, res_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          capture, cnt_inc, idx_inc, res_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_a_q <= bus.op_a;
        op_b_q <= bus.op_b;
        idx_q  <= '0;
        cnt_q  <= '0;
      end else begin
        if (cnt_inc) cnt_q <= cnt_q + 1'b1;
        if (idx_inc) idx_q <= idx_q + 1'b1;
      end
      if (res_load) res_q <= bus.mem_rd;
    end
  end

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    cnt_inc       = 1'b0;
    idx_inc       = 1'b0;
    res_load      = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_a     = '0;
    bus.mem_wd    = '0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          capture = 1'b1;
          state_d = S_WR_A;
        end
      end
      S_WR_A: begin
        bus.mem_we = 1'b1;
        bus.mem_a  = OP_A_ADDR;
        bus.mem_wd = op_a_q;
        state_d    = S_WR_B;
      end
      S_WR_B: begin
        bus.mem_we = 1'b1;
        bus.mem_a  = OP_B_ADDR;
        bus.mem_wd = op_b_q;
        state_d    = S_CLR_FLAG;
      end
      S_CLR_FLAG: begin
        bus.mem_we = 1'b1;
        bus.mem_a  = FLAG_ADDR;
        state_d    = S_POLL;
      end
      S_POLL: begin
        bus.mem_a = FLAG_ADDR;
        // A set flag wins over an expiring counter on the same edge.
        if (bus.mem_rd != '0)      state_d = S_READ;
        else if (cnt_q == CNT_LAST) state_d = S_ERR;
        else                        cnt_inc = 1'b1;
      end
      S_READ: begin
        bus.mem_a = RES_BASE_ADDR + {27'b0, idx_q, 2'b00};
        res_load  = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = S_READ;
          end
        end
      end
      default: begin
        bus.busy = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign bus.res_data = res_q;
  assign bus.res_idx  = idx_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.timeout  = (state_q == S_ERR);

endmodule

// File: tb/tb_dmem_host_port.sv
// Directed bench for dmem_host_port: memory model with a scripted CPU, handshake
// collector, and per-scenario tasks with hand-computed expectations.
module tb_dmem_host_port;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_host_port_if bus ();
  dmem_host_port_if bus2 ();

  dmem_host_port #(.TIMEOUT_CYCLES(64)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  dmem_host_port #(.TIMEOUT_CYCLES(16)) u_dut_to (.clk(clk), .reset_n(reset_n), .bus(bus2));

  logic [31:0] mem [0:7];
  assign bus.mem_rd  = mem[bus.mem_a[4:2]];
  assign bus2.mem_rd = '0;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  c0 = 0;
  int  cpu_at = -1;
  int  prep_seq = 0;
  int  prep_seen = 0;
  int  wcnt2 = 0;
  wr_t wlog[$];

  int exp_res[5] = '{15, 5, 50, 2, 100000};

  logic [31:0] got_data [5];
  int          got_idx [5];
  int          got_cyc [5];
  int          n_got;
  logic [31:0] held_data [8];
  int          held_idx [8];
  int          n_held;
  logic        end_done, end_busy;
  int          end_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory writes land at the negedge; the scripted CPU posts results and the flag.
  always @(negedge clk) begin
    if (prep_seq != prep_seen) begin
      for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_0000 + i;
      mem[7]    = 32'h5;
      prep_seen = prep_seq;
    end
    if (bus.mem_we) begin
      mem[bus.mem_a[4:2]] = bus.mem_wd;
      wlog.push_back('{bus.mem_a, bus.mem_wd, cyc});
    end
    if (cyc == cpu_at) begin
      mem[2] = 32'd15;
      mem[3] = 32'd5;
      mem[4] = 32'd50;
      mem[5] = 32'd2;
      mem[6] = 32'd100000;
      mem[7] = 32'd1;
    end
    if (bus2.mem_we) wcnt2++;
  end

  task automatic prep();
    prep_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc - 1;
  endtask

  task automatic collect(input int hold_idx, input int hold_n, input int start_at);
    n_got  = 0;
    n_held = 0;
    for (int k = 0; k < 150 && n_got < 5; k++) begin
      @(negedge clk);
      bus.start = (start_at > 0 && (cyc - c0) == start_at);
      if (bus.res_valid) begin
        if (int'(bus.res_idx) == hold_idx && n_held < hold_n && n_held < 8) begin
          bus.res_ready     = 1'b0;
          held_data[n_held] = bus.res_data;
          held_idx[n_held]  = int'(bus.res_idx);
          n_held++;
        end else begin
          bus.res_ready  = 1'b1;
          got_data[n_got] = bus.res_data;
          got_idx[n_got]  = int'(bus.res_idx);
          got_cyc[n_got]  = cyc - c0;
          n_got++;
        end
      end else begin
        bus.res_ready = 1'b0;
      end
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    end_done      = bus.done;
    end_busy      = bus.busy;
    end_cyc       = cyc - c0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    bus2.start = 1'b0; bus2.op_a = '0; bus2.op_b = '0; bus2.res_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if ({bus.mem_we, bus.mem_a, bus.mem_wd, bus.res_valid, bus.res_data, bus.res_idx,
         bus.busy, bus.done, bus.timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b a=%h wd=%h v=%b d=%h i=%0d busy=%b done=%b to=%b, want all 0",
               bus.mem_we, bus.mem_a, bus.mem_wd, bus.res_valid, bus.res_data, bus.res_idx,
               bus.busy, bus.done, bus.timeout);
    end
    checks++;
    if ({bus2.mem_we, bus2.mem_a, bus2.mem_wd, bus2.res_valid, bus2.res_data, bus2.res_idx,
         bus2.busy, bus2.done, bus2.timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_to: got busy=%b done=%b to=%b we=%b, want all 0",
               bus2.busy, bus2.done, bus2.timeout, bus2.mem_we);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || wlog.size() != 0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b we=%b writes=%0d, want busy=0 we=0 writes=0",
               bus.busy, bus.mem_we, wlog.size());
    end
  endtask

  task automatic test_nominal();
    int          base;
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    ea = '{32'h00, 32'h04, 32'h1C};
    ed = '{32'd10, 32'd5, 32'd0};
    bus.op_a = 32'd10;
    bus.op_b = 32'd5;
    prep();
    base = wlog.size();
    pulse_start();
    bus.op_a = 32'd99;
    cpu_at = c0 + 20;
    collect(-1, 0, 0);
    cpu_at = -1;
    checks++;
    if (wlog.size() - base != 3) begin
      failures++;
      $display("FAIL nominal_wr_count: got %0d, want 3", wlog.size() - base);
    end
    for (int k = 0; k < 3 && base + k < wlog.size(); k++) begin
      checks++;
      if (wlog[base+k].addr !== ea[k] || wlog[base+k].data !== ed[k] || wlog[base+k].cyc - c0 != k + 1) begin
        failures++;
        $display("FAIL nominal_wr%0d: got a=%h d=%0d cyc=%0d, want a=%h d=%0d cyc=%0d", k,
                 wlog[base+k].addr, wlog[base+k].data, wlog[base+k].cyc - c0, ea[k], ed[k], k + 1);
      end
    end
    checks++;
    if (n_got != 5) begin
      failures++;
      $display("FAIL nominal_count: got %0d handshakes, want 5", n_got);
    end
    for (int k = 0; k < n_got; k++) begin
      checks++;
      if (got_idx[k] != k || got_data[k] !== 32'(exp_res[k]) || got_cyc[k] != 22 + 2 * k) begin
        failures++;
        $display("FAIL nominal_res%0d: got idx=%0d d=%0d cyc=%0d, want idx=%0d d=%0d cyc=%0d", k,
                 got_idx[k], got_data[k], got_cyc[k], k, exp_res[k], 22 + 2 * k);
      end
    end
    checks++;
    if (end_done !== 1'b1 || end_busy !== 1'b0 || end_cyc != 31) begin
      failures++;
      $display("FAIL nominal_done: got done=%b busy=%b cyc=%0d, want done=1 busy=0 cyc=31",
               end_done, end_busy, end_cyc);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int exp_cyc [5];
    exp_cyc = '{22, 24, 33, 35, 37};
    bus.op_a = 32'd7;
    bus.op_b = 32'd3;
    prep();
    base = wlog.size();
    pulse_start();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_done: got done=%b busy=%b, want done=0 busy=1", bus.done, bus.busy);
    end
    cpu_at = c0 + 20;
    collect(2, 7, 8);
    cpu_at = -1;
    checks++;
    if (wlog.size() - base != 3) begin
      failures++;
      $display("FAIL poll_start_ignored: got %0d writes, want 3", wlog.size() - base);
    end
    if (wlog.size() - base >= 2) begin
      checks++;
      if (wlog[base].data !== 32'd7 || wlog[base+1].data !== 32'd3) begin
        failures++;
        $display("FAIL restart_operands: got %0d,%0d, want 7,3", wlog[base].data, wlog[base+1].data);
      end
    end
    checks++;
    if (n_held != 7) begin
      failures++;
      $display("FAIL bp_hold_count: got %0d, want 7", n_held);
    end
    for (int k = 0; k < n_held; k++) begin
      checks++;
      if (held_data[k] !== 32'd50 || held_idx[k] != 2) begin
        failures++;
        $display("FAIL bp_hold%0d: got d=%0d idx=%0d, want d=50 idx=2", k, held_data[k], held_idx[k]);
      end
    end
    for (int k = 0; k < n_got; k++) begin
      checks++;
      if (got_idx[k] != k || got_data[k] !== 32'(exp_res[k]) || got_cyc[k] != exp_cyc[k]) begin
        failures++;
        $display("FAIL bp_res%0d: got idx=%0d d=%0d cyc=%0d, want idx=%0d d=%0d cyc=%0d", k,
                 got_idx[k], got_data[k], got_cyc[k], k, exp_res[k], exp_cyc[k]);
      end
    end
    checks++;
    if (n_got != 5 || end_done !== 1'b1 || end_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: got n=%0d done=%b busy=%b, want n=5 done=1 busy=0", n_got, end_done, end_busy);
    end
  endtask

  task automatic test_timeout();
    int   base;
    int   c2;
    int   first_to;
    logic seen_valid;
    base       = wcnt2;
    first_to   = -1;
    seen_valid = 1'b0;
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    c2 = cyc - 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus2.res_valid) seen_valid = 1'b1;
      if (bus2.timeout === 1'b1 && first_to < 0) first_to = cyc - c2;
    end
    checks++;
    if (first_to != 20) begin
      failures++;
      $display("FAIL timeout_cycle: got %0d, want 20", first_to);
    end
    checks++;
    if (seen_valid !== 1'b0 || bus2.busy !== 1'b0 || bus2.timeout !== 1'b1 || wcnt2 - base != 3) begin
      failures++;
      $display("FAIL timeout_state: got valid_seen=%b busy=%b to=%b writes=%0d, want 0 0 1 3",
               seen_valid, bus2.busy, bus2.timeout, wcnt2 - base);
    end
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    checks++;
    if (bus2.timeout !== 1'b0 || bus2.busy !== 1'b1 || bus2.mem_we !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_err: got to=%b busy=%b we=%b, want 0 1 1", bus2.timeout, bus2.busy, bus2.mem_we);
    end
  endtask

  task automatic test_reset_mid_send();
    int   base;
    logic found;
    found = 1'b0;
    bus.op_a = 32'd1;
    bus.op_b = 32'd2;
    bus.res_ready = 1'b0;
    prep();
    pulse_start();
    cpu_at = c0 + 20;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) found = 1'b1;
    end
    cpu_at = -1;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_send_wait: got no res_valid in 60 cycles, want res_valid");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_a, bus.mem_wd, bus.res_valid, bus.res_data, bus.res_idx,
         bus.busy, bus.done, bus.timeout} !== '0) begin
      failures++;
      $display("FAIL rst_async: got we=%b a=%h v=%b d=%h i=%0d busy=%b, want all 0",
               bus.mem_we, bus.mem_a, bus.res_valid, bus.res_data, bus.res_idx, bus.busy);
    end
    base = wlog.size();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.done !== 1'b0 || wlog.size() != base) begin
      failures++;
      $display("FAIL rst_stay_idle: got busy=%b v=%b done=%b writes=%0d, want 0 0 0 0",
               bus.busy, bus.res_valid, bus.done, wlog.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
